sccb_slave_regs: RTL and testbench
==================================

# sccb_slave_regs

SCCB/I2C-style two-wire responder that terminates the three-phase write transactions issued by our codec/camera init masters (device ID, sub-address, value) and stores each value in an internal register file. It sits on the target side of the SCL/SDA pair: in simulation as a stand-in for the WM8731/OV2640 control port, and in fabric as a soft configuration target. It oversamples SCL/SDA on the system clock, ACKs matching bytes and raises a one-cycle write strobe per stored byte.

## Interface
Parameters:
- DEV_ADDR, 8'h34, 8-bit write address (7-bit ID in [7:1], bit0 = R/W); default is WM8731 with CSB low
- NUM_REGS, 32, register file depth; legal sub-addresses 0..NUM_REGS-1
- AW, $clog2(NUM_REGS), register index width

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset; synchronous, active-low
- scl  in  1  bus clock from master (asynchronous)
- sda_in  in  1  bus data as seen on the pad (asynchronous)
- sda_oe  out  1  1 = pull SDA low (open-drain); pad drives Z when 0
- wr_strobe  out  1  one-cycle pulse per stored data byte
- wr_addr  out  8  sub-address of the stored byte
- wr_data  out  8  stored byte
- dbg_addr  in  AW  register file read index
- dbg_data  out  8  reg[dbg_addr], combinational
- busy  out  1  high from START detect until STOP detect

## Operation
- scl/sda_in pass through 2-flop synchronizers; edges detected on synchronized signals.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both valid in any state.
- Bits sampled on SCL rising edge, MSB first; sda_oe changes only on SCL falling edge.
- States: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, DATA, DATA_ACK, RD, RD_ACK, IGNORE.
- IDLE -> DEV on START; any state -> DEV on START (repeated start); any state -> IDLE on STOP.
- DEV: 8 bits collected; if byte == DEV_ADDR -> DEV_ACK (ACK); if byte == DEV_ADDR|1 see Configuration; else -> IGNORE (no ACK, wait for STOP/START).
- DEV_ACK -> SUB; SUB: 8 bits, always ACKed -> SUB_ACK -> DATA.
- DATA: 8 bits; if sub < NUM_REGS: reg[sub] <= byte, wr_strobe pulses; else byte discarded, no strobe. Always ACKed. DATA_ACK -> DATA with sub <= sub+1 (8-bit wrap 0xFF -> 0x00).
- ACK = sda_oe high for exactly one SCL period (falling edge after 8th bit to next falling edge).
- Reset values: sda_oe 0, wr_strobe 0, wr_addr 0, wr_data 0, busy 0, all registers 8'h00, state IDLE, sub 0.
- Reset mid-transaction: immediate return to IDLE, sda_oe released same cycle reset is sampled; register contents cleared.

## Timing
- Sync + edge detect latency: 3 clk from pad change to internal event.
- wr_strobe asserts 1 clk after the 8th DATA bit's SCL rise is detected; wr_addr/wr_data valid in same cycle, held until next strobe.
- dbg_data reflects a write the cycle after wr_strobe.
- sda_oe rises/falls 1 clk after detected SCL falling edge (≤4 clk from pad edge).
- Requirement on master: SCL high and low phases ≥ 8 clk each; SDA stable ≥ 4 clk around SCL rise. Faster buses unsupported.
- Simultaneous SCL and SDA edge in same sampled cycle: treated as data change, not START/STOP.

## Configuration
- SCCB_SLAVE_READ_EN defined: DEV_ADDR|1 ACKed -> RD; reg[sub] (8'h00 if sub ≥ NUM_REGS) shifted out MSB first, driving low on 0 bits; RD_ACK samples master ACK: ACK -> sub+1, next byte; NACK -> IGNORE.
- Not defined: DEV_ADDR|1 treated as non-matching (NACK, IGNORE); RD/RD_ACK states and read mux absent.

## Structure
- Shared package sccb_pkg: state enum, default DEV_ADDR constants (WM8731 8'h34, OV2640 8'h60), bit-counter width (3), ACK/NACK constants.
- Sub-module sccb_line_sync: 2-flop sync of scl/sda_in plus rise/fall and START/STOP detect; instantiated once.

## Test plan
- Write 0x34, 0x1E, 0x00, STOP -> 3 ACKs, wr_strobe once with wr_addr 0x1E, wr_data 0x00; busy low after STOP.
- Write 0x34, 0x04, 0x12, 0x79 -> reg[4]=0x12, reg[5]=0x79 via dbg_data, two strobes.
- Address 0x60 -> no ACK (sda_oe stays 0 entire transfer), no strobe, registers unchanged.
- Sub-address 0x40, data 0xAA -> ACKed, no wr_strobe, all regs unchanged.
- rst_n low during 5th bit of DATA -> sda_oe 0, state IDLE, registers 0; next full transaction succeeds.
- SCCB_SLAVE_READ_EN: write 0x34,0x07,0x5A; repeated START, 0x35, read 1 byte + NACK -> SDA pattern 0x5A, then IGNORE until STOP.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB/I2C register-file responder.
// Holds the protocol state encoding, default device addresses and bus-level constants.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_IGNORE
    } sccb_state_e;

    localparam logic [7:0] WM8731_ADDR = 8'h34;
    localparam logic [7:0] OV2640_ADDR = 8'h60;
    localparam int         BIT_CNT_W   = 3;
    localparam logic       SDA_ACK     = 1'b0;
    localparam logic       SDA_NACK    = 1'b1;

endpackage

// File: rtl/sccb_line_sync.sv
// Brings the asynchronous SCL/SDA pads into the clk domain and derives
// SCL edges plus START/STOP conditions from the synchronized copies.
module sccb_line_sync (
    input  logic clk,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    // p0/p1: two-flop synchronizer, p2: one-cycle history for edge detection
    always_ff @(posedge clk) begin
        scl_p0 <= scl;
        scl_p1 <= scl_p0;
        scl_p2 <= scl_p1;
        sda_p0 <= sda_in;
        sda_p1 <= sda_p0;
        sda_p2 <= sda_p1;
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign sda_s     = sda_p1;
    // SCL must be stable high across both samples, so a coincident SCL edge counts as a data change
    assign start_det = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
    assign stop_det  = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;

endmodule

// File: rtl/sccb_slave_regs.sv
// SCCB/I2C write responder storing (sub-address, value) pairs in a register file.
// Define SCCB_SLAVE_READ_EN to also answer DEV_ADDR|1 with reads from the register file.
module sccb_slave_regs
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = WM8731_ADDR,
    parameter int         NUM_REGS = 32,
    parameter int         AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_strobe,
    output logic [7:0]    wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data,
    output logic          busy
);

    localparam logic [8:0] NUM_REGS_9 = 9'(NUM_REGS);

    sccb_state_e          state, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [6:0]           shift, shift_d;
    logic [7:0]           sub, sub_d;
    logic [7:0]           byte_in;
    logic                 oe_d, strobe_d, sub_ok;
    logic                 scl_rise, scl_fall, sda_s, start_det, stop_det;
    logic [7:0]           regs [NUM_REGS];
`ifdef SCCB_SLAVE_READ_EN
    logic                 rd_dir, rd_dir_d;
    logic [6:0]           tx, tx_d;
    logic [7:0]           rd_byte;
`endif

    sccb_line_sync u_sync (
        .clk       (clk),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in = {shift, sda_s};
    assign sub_ok  = ({1'b0, sub} < NUM_REGS_9);
`ifdef SCCB_SLAVE_READ_EN
    assign rd_byte = sub_ok ? regs[sub[AW-1:0]] : 8'h00;
`endif

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        sub_d     = sub;
        oe_d      = sda_oe;
        strobe_d  = 1'b0;
`ifdef SCCB_SLAVE_READ_EN
        rd_dir_d  = rd_dir;
        tx_d      = tx;
`endif
        if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_DEV;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else begin
            case (state)
                ST_DEV, ST_SUB, ST_DATA: if (scl_rise) begin
                    shift_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (&bit_cnt) begin
                        if (state == ST_DEV) begin
                            state_d = (byte_in == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
`ifdef SCCB_SLAVE_READ_EN
                            rd_dir_d = (byte_in == (DEV_ADDR | 8'h01));
                            if (rd_dir_d) state_d = ST_DEV_ACK;
`endif
                        end else if (state == ST_SUB) begin
                            sub_d   = byte_in;
                            state_d = ST_SUB_ACK;
                        end else begin
                            strobe_d = sub_ok;
                            state_d  = ST_DATA_ACK;
                        end
                    end
                end
                // First falling edge pulls SDA low, the second one ends the ACK slot
                ST_DEV_ACK, ST_SUB_ACK, ST_DATA_ACK: if (scl_fall) begin
                    oe_d = ~sda_oe;
                    if (sda_oe) begin
                        bit_cnt_d = '0;
                        case (state)
                            ST_DEV_ACK: begin
                                state_d = ST_SUB;
`ifdef SCCB_SLAVE_READ_EN
                                if (rd_dir) begin
                                    state_d = ST_RD;
                                    tx_d    = rd_byte[6:0];
                                    oe_d    = ~rd_byte[7];
                                end
`endif
                            end
                            ST_SUB_ACK: state_d = ST_DATA;
                            default: begin
                                state_d = ST_DATA;
                                sub_d   = sub + 8'd1;
                            end
                        endcase
                    end
                end
`ifdef SCCB_SLAVE_READ_EN
                ST_RD: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt + 1'b1;
                        if (&bit_cnt) state_d = ST_RD_ACK;
                    end else if (scl_fall) begin
                        if (bit_cnt == '0) begin
                            tx_d = rd_byte[6:0];
                            oe_d = ~rd_byte[7];
                        end else begin
                            tx_d = {tx[5:0], 1'b0};
                            oe_d = ~tx[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_fall) begin
                        oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (sda_s == SDA_ACK) begin
                            sub_d     = sub + 8'd1;
                            bit_cnt_d = '0;
                            state_d   = ST_RD;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            sub       <= 8'h00;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
`ifdef SCCB_SLAVE_READ_EN
            rd_dir    <= 1'b0;
            tx        <= '0;
`endif
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            sub       <= sub_d;
            sda_oe    <= oe_d;
            wr_strobe <= strobe_d;
            if (strobe_d) begin
                wr_addr <= sub;
                wr_data <= byte_in;
            end
`ifdef SCCB_SLAVE_READ_EN
            rd_dir    <= rd_dir_d;
            tx        <= tx_d;
`endif
        end
    end

    // Register file commits from the strobe registers, so dbg_data follows one cycle after wr_strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (wr_strobe) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign dbg_data = regs[dbg_addr];
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_sccb_slave_regs.sv
// Scoreboard bench for sccb_slave_regs: a bus-master model issues transactions and
// queues expected SDA pull-down per bit slot and expected register writes.
module tb_sccb_slave_regs;

    localparam int NUM_REGS = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data, dbg_data;
    logic [4:0] dbg_addr = 5'd0;

    assign sda_line = sda_drv & ~sda_oe;

    sccb_slave_regs #(.DEV_ADDR(8'h34), .NUM_REGS(NUM_REGS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] model_regs [NUM_REGS];
    logic       exp_oe_q [$];
    wr_t        exp_wr_q [$];
    logic       slot_req = 1'b0;
    wr_t        mon_wr;
    logic       mon_oe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Bit-slot monitor: compares sda_oe with the queued expectation at mid SCL-high
    always @(negedge clk) begin
        if (slot_req) begin
            if (exp_oe_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL sda_oe_slot: slot with empty expectation queue, sda_oe=%0b", sda_oe);
            end else begin
                mon_oe = exp_oe_q.pop_front();
                check("sda_oe_slot", 32'(sda_oe), 32'(mon_oe));
            end
        end
    end

    // Write monitor: every strobe must match the next expected register write
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (exp_wr_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr_strobe: unexpected strobe addr=%0h data=%0h", wr_addr, wr_data);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_wr.a));
                check("wr_data", 32'(wr_data), 32'(mon_wr.d));
            end
        end
    end

    task automatic slot(input logic exp_oe);
        exp_oe_q.push_back(exp_oe);
        slot_req = 1'b1;
        @(posedge clk);
        slot_req = 1'b0;
    endtask

    // Entered and left with SCL low; 10 clk low, 10 clk high
    task automatic bit_out(input logic b, input logic exp_oe);
        sda_drv = b;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(5);
        slot(exp_oe);
        wait_clk(4);
        scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic byte_out(input logic [7:0] b, input logic exp_ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i], 1'b0);
        bit_out(1'b1, exp_ack);
    endtask

    task automatic byte_rd(input logic [7:0] exp_b, input logic master_ack);
        for (int i = 7; i >= 0; i--) bit_out(1'b1, ~exp_b[i]);
        bit_out(~master_ack, 1'b0);
    endtask

    task automatic start_cond();
        sda_drv = 1'b1;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(5);
        sda_drv = 1'b0;
        wait_clk(5);
        scl = 1'b0;
        wait_clk(5);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic stop_cond();
        sda_drv = 1'b0;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(5);
        sda_drv = 1'b1;
        wait_clk(10);
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), 32'(dbg_data), 32'(model_regs[i]));
        end
        @(posedge clk);
    endtask

    // Reference: a matching device ACKs every byte; in-range sub-addresses store, sub wraps mod 256
    task automatic write_txn(input logic [7:0] dev, input logic [7:0] sub, input logic [7:0] data [$]);
        logic       hit;
        logic [7:0] s;
        hit = (dev == 8'h34);
        s   = sub;
        start_cond();
        byte_out(dev, hit);
        byte_out(sub, hit);
        foreach (data[k]) begin
            if (hit && int'(s) < NUM_REGS) begin
                model_regs[s] = data[k];
                exp_wr_q.push_back('{a: s, d: data[k]});
            end
            byte_out(data[k], hit);
            s = s + 8'd1;
        end
    endtask

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog: simulation exceeded cycle budget, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q [$];
        logic [7:0] dev, sub;
        int         n, r;

        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        wait_clk(5);
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        wait_clk(5);
        check_regs("reset");

        q = {8'h00};
        write_txn(8'h34, 8'h1E, q);
        stop_cond();
        check_regs("t1");

        q = {8'h12, 8'h79};
        write_txn(8'h34, 8'h04, q);
        stop_cond();
        check_regs("t2");

        q = {8'h55};
        write_txn(8'h60, 8'h04, q);
        stop_cond();
        check_regs("t3");

        q = {8'hAA};
        write_txn(8'h34, 8'h40, q);
        stop_cond();
        check_regs("t4");

`ifdef SCCB_SLAVE_READ_EN
        q = {8'h5A};
        write_txn(8'h34, 8'h07, q);
        start_cond();
        byte_out(8'h35, 1'b1);
        byte_rd(8'h5A, 1'b0);
        byte_rd(8'hFF, 1'b0);
        stop_cond();
        check_regs("t5rd");
`else
        q = {8'h5A};
        write_txn(8'h35, 8'h07, q);
        stop_cond();
        check_regs("t5nord");
`endif

        // Reset asserted while the 5th DATA bit is on the bus
        start_cond();
        byte_out(8'h34, 1'b1);
        byte_out(8'h02, 1'b1);
        for (int i = 7; i >= 4; i--) bit_out(1'b1, 1'b0);
        sda_drv = 1'b0;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(3);
        rst_n = 1'b0;
        wait_clk(2);
        @(negedge clk);
        check("midrst_sda_oe", 32'(sda_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(5);
        stop_cond();
        check_regs("midrst");
        q = {8'hC3, 8'h3C};
        write_txn(8'h34, 8'h1F, q);
        stop_cond();
        check_regs("post_rst");

        for (int t = 0; t < 20; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) dev = 8'h34;
            else if (r == 7) dev = 8'h60;
            else begin
                dev = 8'($urandom_range(0, 255));
                while (dev == 8'h34 || dev == 8'h35) dev = 8'($urandom_range(0, 255));
            end
            r = int'($urandom_range(0, 5));
            if (r < 4) sub = 8'($urandom_range(0, NUM_REGS - 1));
            else if (r == 4) sub = 8'($urandom_range(NUM_REGS, 255));
            else sub = 8'($urandom_range(252, 255));
            n = int'($urandom_range(1, 4));
            q = {};
            for (int k = 0; k < n; k++) q.push_back(8'($urandom_range(0, 255)));
            write_txn(dev, sub, q);
            if ($urandom_range(0, 3) != 0 || t == 19) begin
                stop_cond();
                check_regs($sformatf("rnd%0d", t));
            end
        end

        wait_clk(20);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("oe_queue_drained", 32'(exp_oe_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
